if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Fetch-stage producer feeding the IF/ID pipeline register. It owns the PC, issues word requests to instruction memory over a req/gnt + rvalid interface, and buffers returned words in a 2-entry FIFO. It presents {pc, pc+4, instr} to IF/ID and advances only when IF/ID accepts (write enable). Redirects from branch/jump resolution flush the FIFO and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h00000000, PC value loaded at reset.
NOP_INSTR, 32'h00000013, instruction presented when no valid word is available (addi x0,x0,0).

Ports:
i_clk  input  1  clock, rising edge.
i_resetn  input  1  asynchronous active-low reset.
i_we  input  1  IF/ID write enable; 1 = consumer accepts the current output this cycle.
i_redirect  input  1  redirect request; takes priority over everything except reset.
i_redirect_pc  input  32  target PC for the redirect; bits [1:0] ignored (forced 0).
o_imem_req  output  1  request valid.
o_imem_addr  output  32  word-aligned request address.
i_imem_gnt  input  1  request accepted when o_imem_req && i_imem_gnt.
i_imem_rvalid  input  1  response valid; responses return in order, latency >= 1 cycle after grant.
i_imem_rdata  input  32  response instruction word.
o_if_valid  output  1  FIFO head holds a valid fetched instruction.
o_if_pc  output  32  PC of the head entry; 0 when empty.
o_if_p4  output  32  head PC + 4, modulo 2^32; 0 when empty.
o_if_instr  output  32  head instruction; NOP_INSTR when empty.

Behaviour:
- Reset (async, i_resetn=0): fetch_pc=RESET_PC, FIFO empty, outstanding=0, kill=0. Outputs: o_imem_req=0, o_if_valid=0, o_if_pc=0, o_if_p4=0, o_if_instr=NOP_INSTR. o_imem_addr=RESET_PC. Reset mid-transaction drops everything. Responses arriving after reset release are ignored while outstanding=0.
- Credit rule: o_imem_req = !i_redirect && (outstanding + fifo_count < 2). o_imem_addr = fetch_pc. Responses therefore always have space in the FIFO.
- On grant: fetch_pc += 4 (wraps at 2^32). The request PC is pushed into a 2-deep in-order tag queue. outstanding += 1.
- On rvalid: pop the tag queue and decrement outstanding. If kill>0, discard the data and decrement kill. Otherwise push {tag_pc, rdata} into the FIFO.
- Outputs are combinational from the FIFO head, so there is no added latency. Minimum fetch-to-output latency is grant cycle + memory latency. The word is visible in the cycle rvalid is registered, i.e. the cycle after rvalid.
- Pop: o_if_valid && i_we. When the FIFO is empty and i_we=1, the consumer latches NOP_INSTR, which is legal.
- Simultaneous push and pop on the same cycle are both performed. fifo_count is unchanged.
- Redirect (cycle where i_redirect=1):
  - FIFO cleared.
  - fetch_pc <= {i_redirect_pc[31:2],2'b00}.
  - No request is issued that cycle.
  - kill <= outstanding − (i_imem_rvalid ? 1 : 0) + current kill adjustment. Every response belonging to a pre-redirect request is discarded, including one arriving the same cycle.
  - The tag queue continues to pop normally.
  - Fetch resumes the next cycle.
- Back-to-back redirects: the last one wins. kill accumulates correctly because no grants occur during redirect cycles.
- Invariants, checked by assertions:
  - outstanding <= 2.
  - fifo_count + outstanding <= 2.
  - kill <= outstanding.
  - rvalid with outstanding=0 is a protocol error (ignored).

Test Plan:
- Reset release with RESET_PC=0x100 and memory latency 1, i_we=1 constant. Expected: granted addresses are 0x100, 0x104, 0x108… and outputs show pc=0x100, p4=0x104 with the correct instr, one per cycle at steady state.
- Stall: hold i_we=0 for 5 cycles after two words are buffered. Expected: o_imem_req=0 (credits exhausted) and outputs hold pc=0x100. On release, 0x100 then 0x104 pop on consecutive cycles.
- Redirect to 0x2002 with 2 requests outstanding. Expected: both stale responses are discarded and o_if_valid=0 until the first word from 0x2000 arrives. No stale PC is ever output.
- Redirect in the same cycle as an rvalid for 0x104. Expected: that word is not enqueued, kill=1 for the remaining one, and the next valid output has pc=target.
- gnt held low for 3 cycles. Expected: o_imem_req stays high with a stable addr, and the outputs show NOP_INSTR with o_if_valid=0 once the FIFO drains.
- Wrap: RESET_PC=0xFFFFFFFC. Expected: first output p4=0x00000000, next fetch address is 0x00000000. Assert async reset mid-burst; all outputs return to reset values immediately.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch producer: owns the PC, issues word requests to instruction memory,
// buffers in-order responses in a 2-entry FIFO and presents the head to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_we,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_p4,
  output logic [31:0] o_if_instr
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic [XLEN-1:0] fetch_pc;

  // In-order tag queue: PC of each granted but not yet answered request
  logic [XLEN-1:0] tag_pc [DEPTH];
  logic            tag_wr;
  logic            tag_rd;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   kill;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic            fifo_wr;
  logic            fifo_rd;
  logic [CW-1:0]   fifo_count;

  logic [CW:0]     credits_used;
  logic            grant;
  logic            resp;
  logic            kill_dec;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_nxt;
  logic [XLEN-1:0] head_pc;

  // Request credit and handshake decode
  always_comb begin
    credits_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    o_imem_req      = i_resetn && !i_redirect && (credits_used < (CW+1)'(DEPTH));
    o_imem_addr     = fetch_pc;
    grant           = o_imem_req && i_imem_gnt;
    resp            = i_imem_rvalid && (outstanding != '0);
    kill_dec        = resp && (kill != '0);
    push            = resp && !kill_dec && !i_redirect;
    pop             = o_if_valid && i_we && !i_redirect;
    outstanding_nxt = outstanding + CW'(grant) - CW'(resp);
  end

  // FIFO head presented directly to IF/ID
  always_comb begin
    head_pc    = fifo_pc[fifo_rd];
    o_if_valid = (fifo_count != '0);
    o_if_pc    = '0;
    o_if_p4    = '0;
    o_if_instr = NOP_INSTR;
    if (o_if_valid) begin
      o_if_pc    = head_pc;
      o_if_p4    = head_pc + XLEN'(4);
      o_if_instr = fifo_instr[fifo_rd];
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      fetch_pc <= RESET_PC;
    end else if (i_redirect) begin
      fetch_pc <= i_redirect_pc & ~XLEN'(3);
    end else if (grant) begin
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Outstanding/kill accounting; a redirect condemns every request still in flight
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      tag_wr      <= 1'b0;
      tag_rd      <= 1'b0;
      outstanding <= '0;
      kill        <= '0;
    end else begin
      if (grant) tag_wr <= ~tag_wr;
      if (resp)  tag_rd <= ~tag_rd;
      outstanding <= outstanding_nxt;
      if (i_redirect) begin
        kill <= outstanding_nxt;
      end else if (kill_dec) begin
        kill <= kill - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (grant) tag_pc[tag_wr] <= fetch_pc;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_count <= '0;
    end else if (i_redirect) begin
      fifo_wr    <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) fifo_wr <= ~fifo_wr;
      if (pop)  fifo_rd <= ~fifo_rd;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[fifo_wr]    <= tag_pc[tag_rd];
      fifo_instr[fifo_wr] <= i_imem_rdata;
    end
  end

  a_outstanding_max: assert property (@(posedge i_clk) disable iff (!i_resetn)
    outstanding <= CW'(DEPTH));
  a_credit_max: assert property (@(posedge i_clk) disable iff (!i_resetn)
    credits_used <= (CW+1)'(DEPTH));
  a_kill_le_outstanding: assert property (@(posedge i_clk) disable iff (!i_resetn)
    kill <= outstanding);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: memory slave with random grant/latency, and a
// PC-stream reference model whose expected outputs are queued and checked by a monitor.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        redir;
  logic [31:0] redir_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] p4;
  logic [31:0] instr;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_resetn(rst_n), .i_we(we), .i_redirect(redir), .i_redirect_pc(redir_pc),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata), .o_if_valid(valid), .o_if_pc(pc), .o_if_p4(p4), .o_if_instr(instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] exp_fetch;
  int unsigned cyc;
  int          n_tests;
  int          n_fail;
  int          n_acc;

  int unsigned we_pct, gnt_pct, rv_pct, redir_pct, lat_max;
  logic        force_redir;
  logic [31:0] force_pc;

  logic        prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
  endfunction

  function automatic logic pct(input int unsigned p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected IF/ID output stream restarts at each reset/redirect target
  task automatic stream_reset(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(t + 32'(4 * i));
    exp_tail  = t + 32'd12;
    exp_fetch = t;
  endtask

  // Monitor: samples mid-cycle, predicts what the coming edge commits
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req   = 1'b0;
      prev_gnt   = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_req && !prev_gnt && !prev_redir && !redir) begin
        chk("req_held", {31'd0, req}, 32'd1);
        chk("addr_held", addr, prev_addr);
      end
      if (valid) begin
        chk("head_pc", pc, exp_q[0]);
        chk("head_p4", p4, exp_q[0] + 32'd4);
        chk("head_instr", instr, mem_word(exp_q[0]));
        if (we && !redir) begin
          void'(exp_q.pop_front());
          exp_tail = exp_tail + 32'd4;
          exp_q.push_back(exp_tail);
          n_acc++;
        end
      end else begin
        chk("empty_pc", pc, 32'd0);
        chk("empty_p4", p4, 32'd0);
        chk("empty_instr", instr, NOP);
      end
      if (rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (redir) begin
        chk("req_on_redirect", {31'd0, req}, 32'd0);
        stream_reset(redir_pc & ~32'd3);
      end else if (req && gnt) begin
        chk("grant_addr", addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        mem_q.push_back('{addr: addr, ready: cyc + 1 + $urandom_range(0, lat_max)});
        chk("in_flight_le2", 32'(mem_q.size() <= 2), 32'd1);
      end
      prev_req   = req;
      prev_gnt   = gnt;
      prev_redir = redir;
      prev_addr  = addr;
    end
    cyc++;
  end

  task automatic drive();
    we  = pct(we_pct);
    gnt = pct(gnt_pct);
    if (force_redir) begin
      redir       = 1'b1;
      redir_pc    = force_pc;
      force_redir = 1'b0;
    end else if (pct(redir_pct)) begin
      redir    = 1'b1;
      redir_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
    end else begin
      redir = 1'b0;
    end
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && pct(rv_pct)) begin
      rvalid = 1'b1;
      rdata  = mem_word(mem_q[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic set_mode(input int unsigned w, input int unsigned g, input int unsigned r,
                          input int unsigned rd, input int unsigned lat);
    we_pct = w; gnt_pct = g; rv_pct = r; redir_pct = rd; lat_max = lat;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, req}, 32'd0);
    chk({tag, "_addr"}, addr, RST_PC);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_p4"}, p4, 32'd0);
    chk({tag, "_instr"}, instr, NOP);
  endtask

  int acc_base;

  initial begin
    n_tests = 0; n_fail = 0; n_acc = 0; cyc = 0;
    rst_n = 1'b0; we = 1'b0; redir = 1'b0; redir_pc = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    force_redir = 1'b0; force_pc = '0;
    set_mode(100, 100, 100, 0, 0);
    stream_reset(RST_PC);
    repeat (3) @(posedge clk);
    #1;
    gnt = 1'b1; we = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Steady streaming, latency 1
    acc_base = n_acc;
    run(20);
    chk("steady_throughput", 32'(n_acc - acc_base >= 10), 32'd1);

    // Consumer stall: credits run out, head holds
    set_mode(0, 100, 100, 0, 0);
    run(6);
    chk("stall_req", {31'd0, req}, 32'd0);
    chk("stall_valid", {31'd0, valid}, 32'd1);
    chk("stall_pc", pc, exp_q[0]);
    set_mode(100, 100, 100, 0, 0);
    run(6);

    // Redirect with requests in flight
    set_mode(100, 100, 100, 0, 3);
    run(5);
    force_redir = 1'b1; force_pc = 32'h0000_2002;
    run(25);

    // Grant withheld: request held steady, FIFO drains to NOP
    set_mode(100, 100, 100, 0, 0);
    run(10);
    set_mode(100, 0, 100, 0, 0);
    run(6);
    chk("nognt_req", {31'd0, req}, 32'd1);
    chk("nognt_valid", {31'd0, valid}, 32'd0);
    chk("nognt_instr", instr, NOP);
    chk("nognt_pc", pc, 32'd0);

    // Random mix of stalls, grant gaps, latency and redirects
    set_mode(70, 60, 60, 3, 3);
    run(3000);

    // Address wrap at 2^32
    set_mode(100, 100, 100, 0, 0);
    run(10);
    acc_base = n_acc;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    run(12);
    chk("wrap_progress", 32'(n_acc - acc_base >= 5), 32'd1);

    // Asynchronous reset mid-burst
    set_mode(100, 100, 100, 0, 2);
    run(7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mem_q.delete();
    rvalid = 1'b0; redir = 1'b0;
    stream_reset(RST_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_base = n_acc;
    set_mode(100, 100, 100, 0, 0);
    run(20);
    chk("post_reset_progress", 32'(n_acc - acc_base >= 10), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
